// File: rtl/icache_data_array_nway.sv
// icache_data_array_nway: N-way I-cache data store, 1-cycle line reads, multi-beat refill writes.
// Define ICACHE_DATA_PARITY_EN to store and check per-beat even parity.
module icache_data_array_nway #(
  parameter int NUM_WAYS = 2,
  parameter int LINE_WIDTH = 256,
  parameter int INDEX_WIDTH = 6,
  parameter int BEAT_WIDTH = 64,
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH,
  localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1,
  localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_valid_i,
  output logic                   rd_ready_o,
  input  logic [INDEX_WIDTH-1:0] rd_index_i,
  input  logic [NUM_WAYS-1:0]    rd_way_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   par_err_o,
  input  logic                   rf_valid_i,
  output logic                   rf_ready_o,
  input  logic [INDEX_WIDTH-1:0] rf_index_i,
  input  logic [WAY_W-1:0]       rf_way_i,
  input  logic [BEAT_WIDTH-1:0]  rf_data_i,
  output logic                   rf_done_o
);
  typedef enum logic {IDLE, FILL} state_t;
  state_t st, st_n;
  logic [CNT_W-1:0] cnt, cnt_n, wr_beat;
  logic [INDEX_WIDTH-1:0] idx_q, wr_idx;
  logic [WAY_W-1:0] way_q, wr_way;
  logic [BEAT_WIDTH-1:0] mem [NUM_WAYS][2**INDEX_WIDTH][BEATS];
  logic [LINE_WIDTH-1:0] rd_line;
  logic rd_err, rd_acc, wr_en, last, done_n;
  assign rf_ready_o = rst_i;
  assign rd_ready_o = st == IDLE && !rf_valid_i && (!rsp_valid_o || rsp_ready_i);
  assign rd_acc = rd_valid_i && rd_ready_o;
  // beat 0 addresses the line straight from the ports; later beats use the latched copy
  assign wr_idx = st == IDLE ? rf_index_i : idx_q;
  assign wr_way = st == IDLE ? rf_way_i : way_q;
  assign wr_beat = st == IDLE ? '0 : cnt;
  assign last = wr_beat == CNT_W'(BEATS - 1);
  assign wr_en = rf_valid_i && rst_i && 32'(wr_way) < NUM_WAYS;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    done_n = 1'b0;
    if (rf_valid_i) begin
      st_n = last ? IDLE : FILL;
      cnt_n = last ? '0 : wr_beat + 1'b1;
      done_n = last;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st <= IDLE;
      cnt <= '0;
      rf_done_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o <= '0;
      par_err_o <= 1'b0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      rf_done_o <= done_n;
      if (st == IDLE && rf_valid_i) begin
        idx_q <= rf_index_i;
        way_q <= rf_way_i;
      end
      if (rd_acc) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o <= rd_line;
        par_err_o <= rd_err;
      end else if (rsp_ready_i) rsp_valid_o <= 1'b0;
    end
  end
  always_ff @(posedge clk_i) if (wr_en) mem[wr_way][wr_idx][wr_beat] <= rf_data_i;
`ifdef ICACHE_DATA_PARITY_EN
  logic par [NUM_WAYS][2**INDEX_WIDTH][BEATS];
  always_ff @(posedge clk_i) if (wr_en) par[wr_way][wr_idx][wr_beat] <= ^rf_data_i;
`endif
  // multi-hot way selects OR the lines together
  always_comb begin
    rd_line = '0;
    rd_err = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++)
      for (int b = 0; b < BEATS; b++)
        if (rd_way_i[w]) begin
          rd_line[b*BEAT_WIDTH +: BEAT_WIDTH] = rd_line[b*BEAT_WIDTH +: BEAT_WIDTH] | mem[w][rd_index_i][b];
`ifdef ICACHE_DATA_PARITY_EN
          rd_err = rd_err | ((^mem[w][rd_index_i][b]) != par[w][rd_index_i][b]);
`endif
        end
  end
endmodule
